// File: rtl/display_pkg.sv
// Shared constants for the multiplexed seven-segment display driver:
// active-low segment patterns and parameter legality checks.
package display_pkg;

    // All segments and the decimal point dark (active-low bus).
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low hex glyphs, dp off; entry n is the pattern for nibble n.
    localparam logic [15:0][7:0] SEG_HEX = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic bit digits_ok(int digits);
        return (digits >= 1) && (digits <= 8);
    endfunction

    // A slot must be long enough to resolve every brightness step.
    function automatic bit div_ok(int div, int bright_w);
        return (div >= 2) && (div >= (1 << bright_w));
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble plus decimal point to active-low segments.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] hex_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    // Glyph lookup with the dp bit inverted onto the active-low bus.
    always_comb begin
        seg_o = {~dp_i, SEG_HEX[hex_i][6:0]};
    end

endmodule

// File: rtl/display_mux.sv
// Time-multiplexed seven-segment driver with frame-synchronous snapshots,
// brightness PWM inside each digit slot, a dark anti-ghosting cycle at the
// start of every slot and a one-cycle frame pulse.
// Optional macro DISPLAY_LZ_BLANK_EN enables leading-zero suppression.
module display_mux
    import display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DIV      = 5000,
    parameter int BRIGHT_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  on,
    input  logic [4*DIGITS-1:0]   number,
    input  logic [DIGITS-1:0]     dp,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [DIGITS-1:0]     AN,
    output logic [7:0]            BCD,
    output logic                  frame_done
);

    localparam int CNT_W  = $clog2(DIV);
    localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (!digits_ok(DIGITS) || !div_ok(DIV, BRIGHT_W)) begin : g_param_err
        $error("display_mux: DIGITS must be 1..8 and DIV >= max(2, 2**BRIGHT_W)");
    end

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [4*DIGITS-1:0] num_q;
    logic [DIGITS-1:0]   dp_q;
    logic [BRIGHT_W-1:0] bright_q;
    logic                wrap;
    logic                load;
    logic [SLOT_W-1:0]   sel;
    logic [31:0]         thr;
    logic                lit;
    logic                show;
    logic [7:0]          seg;
    logic [DIGITS-1:0]   an_d;
    logic [7:0]          bcd_d;
    logic [DIGITS-1:0]   an_q;
    logic [7:0]          bcd_q;
    logic                fd_q;

    // Prescaler and slot sequencing; both held at zero while the display is off.
    always_comb begin
        cnt_d  = cnt_q;
        slot_d = slot_q;
        wrap   = 1'b0;
        if (!on) begin
            cnt_d  = '0;
            slot_d = '0;
        end else if (cnt_q == CNT_W'(DIV - 1)) begin
            cnt_d = '0;
            if (slot_q == SLOT_W'(DIGITS - 1)) begin
                slot_d = '0;
                wrap   = 1'b1;
            end else begin
                slot_d = slot_q + SLOT_W'(1);
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        load = !on || wrap;
    end

    // Scan state and frame snapshot of the inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            slot_q   <= '0;
            num_q    <= '0;
            dp_q     <= '0;
            bright_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
            if (load) begin
                num_q    <= number;
                dp_q     <= dp;
                bright_q <= brightness;
            end
        end
    end

`ifdef DISPLAY_LZ_BLANK_EN
    logic [DIGITS-1:0] show_q, show_d;
    logic              seen_nz;

    // Visible-digit mask for the incoming snapshot: everything from the
    // highest non-zero digit down, digit 0, and any digit carrying a dp.
    always_comb begin
        show_d  = '0;
        seen_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen_nz   = seen_nz | (number[4*i +: 4] != 4'h0);
            show_d[i] = seen_nz | dp[i] | (i == 0);
        end
    end

    // Mask is captured alongside the snapshot so it is fixed for the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            show_q <= DIGITS'(1);
        end else if (load) begin
            show_q <= show_d;
        end
    end

    assign show = show_q[sel];
`else
    assign show = 1'b1;
`endif

    // Slot s drives the leftmost-first digit; lit window follows brightness.
    always_comb begin
        sel = SLOT_W'(DIGITS - 1) - slot_q;
        thr = ((32'(bright_q) + 32'd1) * 32'(DIV)) >> BRIGHT_W;
        lit = on && (cnt_q != '0) && (32'(cnt_q) <= thr) && show;
    end

    seg7_decode u_dec (
        .hex_i (num_q[4*sel +: 4]),
        .dp_i  (dp_q[sel]),
        .seg_o (seg)
    );

    // Anode and segment values for the current scan position.
    always_comb begin
        an_d  = '1;
        bcd_d = SEG_OFF;
        if (lit) begin
            an_d[sel] = 1'b0;
            bcd_d     = seg;
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q  <= '1;
            bcd_q <= SEG_OFF;
            fd_q  <= 1'b0;
        end else begin
            an_q  <= an_d;
            bcd_q <= bcd_d;
            fd_q  <= wrap;
        end
    end

    assign AN         = an_q;
    assign BCD        = bcd_q;
    assign frame_done = fd_q;

endmodule
